// File: rtl/ula_pkg.sv
// Shared definitions for the serial 74181 ALU: select codes, FSM state, control bundle
// and the carry-polarity rule used when chaining nibbles.
package ula_pkg;

  localparam logic [3:0] S_A                 = 4'b0000;
  localparam logic [3:0] S_A_OR_B            = 4'b0001;
  localparam logic [3:0] S_A_OR_NB           = 4'b0010;
  localparam logic [3:0] S_MINUS_1           = 4'b0011;
  localparam logic [3:0] S_A_MINUS_B_MINUS_1 = 4'b0110;
  localparam logic [3:0] S_A_AND_NB_MINUS_1  = 4'b0111;
  localparam logic [3:0] S_A_PLUS_B          = 4'b1001;
  localparam logic [3:0] S_AB_MINUS_1        = 4'b1011;
  localparam logic [3:0] S_A_PLUS_A          = 4'b1100;
  localparam logic [3:0] S_A_MINUS_1         = 4'b1111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } ctl_t;

  // Ops whose c_out reads as a borrow; the chain must re-invert it into a carry.
  function automatic logic is_borrow_op(input logic [3:0] sel);
    case (sel)
      S_A, S_A_OR_NB, S_MINUS_1, S_A_MINUS_B_MINUS_1,
      S_A_AND_NB_MINUS_1, S_AB_MINUS_1: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_74181.sv
// One 4-bit 74181-style slice with active-high data and active-high carry in.
// c_out is reported as a borrow for the ops flagged by is_borrow_op.
module ula_74181
  import ula_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b
);

  logic [3:0] x, y;
  logic [4:0] sum;

  always_comb begin
    // Same propagate/generate terms the real part uses; logic mode is their XNOR.
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
    if (m) begin
      f     = ~(x ^ y);
      c_out = 1'b0;
    end else begin
      f     = sum[3:0];
      c_out = is_borrow_op(s) ? ~sum[4] : sum[4];
    end
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_serial_16.sv
// Nibble-serial ALU: one ula_74181 slice walks NIBBLES nibbles, one per clock.
// Optional `ULA_SERIAL_ZERO_FLAG_EN adds a registered zero flag output.
module ula_serial_16
  import ula_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] f,
  output logic                 c_out,
  output logic                 a_eq_b
`ifdef ULA_SERIAL_ZERO_FLAG_EN
  ,
  output logic                 zero
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d;
  ctl_t            ctl_q, ctl_d;
  logic [W-1:0]    f_q, f_d;
  logic            c_out_q, c_out_d;
  logic            eq_acc_q, eq_acc_d;
  logic            a_eq_b_q, a_eq_b_d;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
  logic            zero_q, zero_d;
`endif

  logic [3:0] nib_f;
  logic       nib_c, nib_eq;

  ula_74181 u_alu (
    .a      (op_a_q[4*cnt_q +: 4]),
    .b      (op_b_q[4*cnt_q +: 4]),
    .s      (ctl_q.s),
    .m      (ctl_q.m),
    .c_in   (carry_q),
    .f      (nib_f),
    .c_out  (nib_c),
    .a_eq_b (nib_eq)
  );

  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    ctl_d    = ctl_q;
    f_d      = f_q;
    c_out_d  = c_out_q;
    eq_acc_d = eq_acc_q;
    a_eq_b_d = a_eq_b_q;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    case (state_q)
      RUN: begin
        f_d[4*cnt_q +: 4] = nib_f;
        eq_acc_d = eq_acc_q & nib_eq;
        carry_d  = is_borrow_op(ctl_q.s) ? ~nib_c : nib_c;
        if (cnt_q == LAST) begin
          // Last nibble: publish the flags and hold the counter in range.
          state_d  = DONE;
          done_d   = 1'b1;
          c_out_d  = nib_c;
          a_eq_b_d = eq_acc_d;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
          zero_d   = (f_d == '0);
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          op_a_d   = op_a;
          op_b_d   = op_b;
          ctl_d    = '{s: s, m: m};
          cnt_d    = '0;
          carry_d  = c_in;
          eq_acc_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      ctl_q    <= '0;
      f_q      <= '0;
      c_out_q  <= 1'b0;
      eq_acc_q <= 1'b0;
      a_eq_b_q <= 1'b0;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      ctl_q    <= ctl_d;
      f_q      <= f_d;
      c_out_q  <= c_out_d;
      eq_acc_q <= eq_acc_d;
      a_eq_b_q <= a_eq_b_d;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign f      = f_q;
  assign c_out  = c_out_q;
  assign a_eq_b = a_eq_b_q;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_ula_serial_16.sv
// Bench for ula_serial_16: word-level 74181 model plus directed literal cases and random traffic.
// Checks the zero flag too when built with ULA_SERIAL_ZERO_FLAG_EN.
module tb_ula_serial_16;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [3:0]  s = '0;
  logic        m = 1'b0, c_in = 1'b0;
  logic        busy, done, c_out, a_eq_b;
  logic [15:0] f;
`ifdef ULA_SERIAL_ZERO_FLAG_EN
  logic        zero;
`endif

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  ula_serial_16 #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .s(s), .m(m), .c_in(c_in), .busy(busy), .done(done), .f(f),
    .c_out(c_out), .a_eq_b(a_eq_b)
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Whole-word 74181 function table; returns {a_eq_b, c_out, f}.
  function automatic logic [17:0] calc(input logic [15:0] a, b, input logic [3:0] sv,
                                       input logic mv, cv);
    logic [15:0] x, y, r;
    logic [16:0] sum;
    logic        co;
    x = '0; y = '0; r = '0; co = 1'b0; sum = '0;
    if (mv) begin
      case (sv)
        4'h0: r = ~a;        4'h1: r = ~(a | b);  4'h2: r = ~a & b;     4'h3: r = 16'h0000;
        4'h4: r = ~(a & b);  4'h5: r = ~b;        4'h6: r = a ^ b;      4'h7: r = a & ~b;
        4'h8: r = ~a | b;    4'h9: r = ~(a ^ b);  4'hA: r = b;          4'hB: r = a & b;
        4'hC: r = 16'hFFFF;  4'hD: r = a | ~b;    4'hE: r = a | b;      default: r = a;
      endcase
    end else begin
      case (sv)
        4'h0: begin x = a;        y = 16'h0;    end
        4'h1: begin x = a | b;    y = 16'h0;    end
        4'h2: begin x = a | ~b;   y = 16'h0;    end
        4'h3: begin x = 16'hFFFF; y = 16'h0;    end
        4'h4: begin x = a;        y = a & ~b;   end
        4'h5: begin x = a | b;    y = a & ~b;   end
        4'h6: begin x = a;        y = ~b;       end
        4'h7: begin x = a & ~b;   y = 16'hFFFF; end
        4'h8: begin x = a;        y = a & b;    end
        4'h9: begin x = a;        y = b;        end
        4'hA: begin x = a | ~b;   y = a & b;    end
        4'hB: begin x = a & b;    y = 16'hFFFF; end
        4'hC: begin x = a;        y = a;        end
        4'hD: begin x = a | b;    y = a;        end
        4'hE: begin x = a | ~b;   y = a;        end
        default: begin x = a;     y = 16'hFFFF; end
      endcase
      sum = {1'b0, x} + {1'b0, y} + {16'h0, cv};
      r   = sum[15:0];
      co  = (sv inside {4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'hB}) ? ~sum[16] : sum[16];
    end
    return {(r == 16'hFFFF), co, r};
  endfunction

  // Reference: phase 0 idle, 1 run, 2 done; f fills from the low nibble up.
  int          mph = 0, mk = 0;
  logic [15:0] m_f = '0, old_f = '0, r_f = '0;
  logic        m_c = 1'b0, m_eq = 1'b0, m_z = 1'b0, r_c = 1'b0, r_eq = 1'b0;

  always @(posedge clk) begin
    logic [17:0] res;
    logic [31:0] mask;
    if (rst) begin
      mph = 0; m_f = '0; m_c = 1'b0; m_eq = 1'b0; m_z = 1'b0;
    end else if (mph != 1 && start) begin
      res = calc(op_a, op_b, s, m, c_in);
      {r_eq, r_c, r_f} = res;
      old_f = m_f; mk = 0; mph = 1;
    end else if (mph == 1) begin
      mk++;
      mask = (32'h1 << (4 * mk)) - 32'h1;
      m_f  = (r_f & mask[15:0]) | (old_f & ~mask[15:0]);
      if (mk == NIB) begin
        mph = 2; m_c = r_c; m_eq = r_eq; m_z = (r_f == 16'h0);
      end
    end else begin
      mph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_busy", 32'(busy), 32'(mph == 1));
      chk("mdl_done", 32'(done), 32'(mph == 2));
      chk("mdl_f", 32'(f), 32'(m_f));
      if (mph != 1) begin
        chk("mdl_c_out", 32'(c_out), 32'(m_c));
        chk("mdl_a_eq_b", 32'(a_eq_b), 32'(m_eq));
      end
`ifdef ULA_SERIAL_ZERO_FLAG_EN
      chk("mdl_zero", 32'(zero), 32'(m_z));
`endif
    end
  end

  // One operation from idle; checks done latency, busy span and literal results.
  task automatic run_op(input string nm, input logic [15:0] a, b, input logic [3:0] sv,
                        input logic mv, cv, input logic [15:0] ef, input logic ec, ee);
    int dcyc = 0, bcnt = 0;
    op_a = a; op_b = b; s = sv; m = mv; c_in = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 20 && dcyc == 0; n++) begin
      if (busy) bcnt++;
      if (done) dcyc = n;
      if (dcyc == 0) @(negedge clk);
    end
    chk({nm, "_done_cycle"}, 32'(dcyc), 32'd5);
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'd4);
    chk({nm, "_f"}, 32'(f), 32'(ef));
    chk({nm, "_c_out"}, 32'(c_out), 32'(ec));
    chk({nm, "_a_eq_b"}, 32'(a_eq_b), 32'(ee));
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   dcyc;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_a_eq_b", 32'(a_eq_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add",      16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op("add_ripl", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub",      16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    run_op("xor",      16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0);
    run_op("sub_eq",   16'h3C3C, 16'h3C3C, 4'b0110, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1);

    // Second start mid-RUN must not disturb the operation in flight.
    op_a = 16'h1234; op_b = 16'h0FCD; s = 4'b1001; m = 1'b0; c_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; s = 4'b0000;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_f", 32'(f), 32'h2201);
    repeat (2) @(negedge clk);

    // Reset in cycle 2 of RUN aborts with no done pulse.
    op_a = 16'hABCD; op_b = 16'h1111; s = 4'b1001; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_f", 32'(f), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // Back-to-back: start held through DONE.
    op_a = 16'hFFFF; op_b = 16'h0001; s = 4'b1001; m = 1'b0; c_in = 1'b0; start = 1'b1;
    repeat (4) @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FCD;
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_f1", 32'(f), 32'h0000);
    chk("b2b_c1", 32'(c_out), 32'd1);
`ifdef ULA_SERIAL_ZERO_FLAG_EN
    chk("b2b_zero", 32'(zero), 32'd1);
`endif
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy2", 32'(busy), 32'd1);
    dcyc = 0;
    for (int n = 7; n <= 20 && dcyc == 0; n++) begin
      @(negedge clk);
      if (done) dcyc = n;
    end
    chk("b2b_done2_cycle", 32'(dcyc), 32'd10);
    chk("b2b_f2", 32'(f), 32'h2201);
    repeat (2) @(negedge clk);

    // Random traffic against the model, including starts during RUN and stray resets.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      s     = 4'($urandom);
      m     = 1'($urandom);
      c_in  = 1'($urandom);
      rst   = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
